// File: rtl/tp_pulse_stretcher_if.sv
// Test-point bus between the PIO out_port and the TP header conditioner.
// master drives raw levels and per-bit bypass; slave returns conditioned levels and hold status.
// All signals are WIDTH bits, one lane per test point, no handshake (level bus).
interface tp_pulse_stretcher_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] gpio_in;   // raw test-point levels from the PIO
    logic [WIDTH-1:0] bypass;    // per-bit: 1 = pass through unstretched
    logic [WIDTH-1:0] tp_out;    // conditioned levels to the TP pins
    logic [WIDTH-1:0] busy;      // per-bit: hold counter non-zero

    modport master (
        output gpio_in,
        output bypass,
        input  tp_out,
        input  busy
    );

    modport slave (
        input  gpio_in,
        input  bypass,
        output tp_out,
        output busy
    );
endinterface

// File: rtl/tp_pulse_stretcher.sv
// Per-bit pulse stretcher: every tp_out level is held for at least MIN_CYCLES clocks.
// Latency: gpio_in edge to tp_out edge is 2 cycles when idle (4 with TP_STRETCH_SYNC_EN defined).
// No backpressure: level bus; changes arriving during a hold are deferred, never dropped.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous, active-low reset
//   tp_if    slave side of tp_pulse_stretcher_if (gpio_in, bypass in; tp_out, busy out)
//
// Optional macro TP_STRETCH_SYNC_EN: inserts a 2-flop synchronizer on gpio_in and
// bypass for use when the PIO runs in another clock domain.
module tp_pulse_stretcher #(
    parameter int WIDTH      = 8,
    parameter int MIN_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    tp_pulse_stretcher_if.slave tp_if
);

    localparam int CW = $clog2(MIN_CYCLES + 1);
    // Loaded on every output toggle; the toggle cycle itself counts as one of
    // the MIN_CYCLES, so the counter runs MIN_CYCLES-1 .. 0.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } bit_state_t;

    logic [WIDTH-1:0] gpio_src;
    logic [WIDTH-1:0] byp_eff;

`ifdef TP_STRETCH_SYNC_EN
    logic [WIDTH-1:0] gpio_s1_q;
    logic [WIDTH-1:0] gpio_s2_q;
    logic [WIDTH-1:0] byp_s1_q;
    logic [WIDTH-1:0] byp_s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_s1_q <= '0;
            gpio_s2_q <= '0;
            byp_s1_q  <= '0;
            byp_s2_q  <= '0;
        end else begin
            gpio_s1_q <= tp_if.gpio_in;
            gpio_s2_q <= gpio_s1_q;
            byp_s1_q  <= tp_if.bypass;
            byp_s2_q  <= byp_s1_q;
        end
    end

    assign gpio_src = gpio_s2_q;
    assign byp_eff  = byp_s2_q;
`else
    assign gpio_src = tp_if.gpio_in;
    assign byp_eff  = tp_if.bypass;
`endif

    // Per-bit state: {tp_q, cnt_q, pend_q}; IDLE/HOLD is decoded from cnt_q.
    logic [WIDTH-1:0] in_q,   in_d;
    logic [WIDTH-1:0] tp_q,   tp_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    bit_state_t       st    [WIDTH];
    logic [WIDTH-1:0] mism;

    assign mism = in_q ^ tp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= '0;
            tp_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            in_q   <= in_d;
            tp_q   <= tp_d;
            pend_q <= pend_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            st[i] = (cnt_q[i] != '0) ? ST_HOLD : ST_IDLE;
        end
    end

    always_comb begin
        in_d   = gpio_src;
        tp_d   = tp_q;
        pend_d = pend_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        for (int i = 0; i < WIDTH; i++) begin
            if (byp_eff[i]) begin
                // Registered pass-through; any hold in progress is abandoned.
                tp_d[i]   = in_q[i];
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else begin
                case (st[i])
                    ST_IDLE: begin
                        // pend alone can fire a toggle: a pulse that opened and
                        // closed inside the previous hold leaves in_q==tp_q but
                        // still has to appear once on the pin.
                        if (mism[i] || pend_q[i]) begin
                            tp_d[i]   = ~tp_q[i];
                            cnt_d[i]  = HOLD_LOAD;
                            pend_d[i] = 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        cnt_d[i]  = cnt_q[i] - CW'(1);
                        pend_d[i] = pend_q[i] | mism[i];
                    end
                    default: begin
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            tp_if.busy[i] = (cnt_q[i] != '0);
        end
    end

    assign tp_if.tp_out = tp_q;

endmodule

// File: tb/tb_tp_pulse_stretcher.sv
module tb_tp_pulse_stretcher;

`ifdef TP_STRETCH_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int D    = LAT - 2;
    localparam int SEGL = 32;
    localparam int NSEG = 8;

    logic clk;
    logic reset_n;

    tp_pulse_stretcher_if #(.WIDTH(8)) tp_if ();

    tp_pulse_stretcher #(
        .WIDTH      (8),
        .MIN_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tp_if   (tp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tp;
        logic [7:0] busy;
        int         seg;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Window [a,b] in cycles after the stimulus cycle, shifted by extra sync latency.
    function automatic logic win(int c, int a, int b);
        return (c >= a + D) && (c <= b + D);
    endfunction

    function automatic void stim(input int s, input int c,
                                 output logic [7:0] g, output logic [7:0] b,
                                 output logic r);
        g = 8'h00;
        b = 8'h00;
        r = 1'b1;
        case (s)
            0: r = (c >= 3);                               // reset, then idle
            1: g[0] = (c == 0);                            // single-cycle pulse
            2: g[3] = (c <= 19);                           // 20-cycle level
            3: g[5] = (c == 0) || (c == 2) || (c == 4);    // burst inside one hold
            4: begin b = 8'hFF; g[7] = (c == 0); end       // full bypass
            5: begin g[1] = (c == 0); g[4] = (c == 5); end // two independent bits
            6: begin g[6] = (c == 0); b[6] = (c >= 4); end // bypass mid-hold
            7: begin g[2] = (c == 0); r = !((c == 5) || (c == 6)); end // reset mid-hold
            default: ;
        endcase
    endfunction

    function automatic exp_t expect_for(input int s, input int c);
        exp_t e;
        e.tp   = 8'h00;
        e.busy = 8'h00;
        e.seg  = s;
        e.cyc  = c;
        case (s)
            1: begin
                e.tp[0]   = win(c, 2, 9);
                e.busy[0] = win(c, 2, 8) || win(c, 10, 16);
            end
            2: begin
                e.tp[3]   = win(c, 2, 21);
                e.busy[3] = win(c, 2, 8) || win(c, 22, 28);
            end
            3: begin
                e.tp[5]   = win(c, 2, 9);
                e.busy[5] = win(c, 2, 8) || win(c, 10, 16);
            end
            4: e.tp[7] = win(c, 2, 2);
            5: begin
                e.tp[1]   = win(c, 2, 9);
                e.busy[1] = win(c, 2, 8) || win(c, 10, 16);
                e.tp[4]   = win(c, 7, 14);
                e.busy[4] = win(c, 7, 13) || win(c, 15, 21);
            end
            6: begin
                e.tp[6]   = win(c, 2, 4);
                e.busy[6] = win(c, 2, 4);
            end
            7: begin
                // reset at cycle 5 truncates the hold regardless of latency
                e.tp[2]   = (c >= LAT) && (c <= 4);
                e.busy[2] = (c >= LAT) && (c <= 4);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: compares the DUT against the queued expectation every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (tp_if.tp_out === e.tp) n_pass++;
                else $display("FAIL tp_out seg%0d cyc%0d: got %h expected %h",
                              e.seg, e.cyc, tp_if.tp_out, e.tp);
                n_total++;
                if (tp_if.busy === e.busy) n_pass++;
                else $display("FAIL busy seg%0d cyc%0d: got %h expected %h",
                              e.seg, e.cyc, tp_if.busy, e.busy);
            end
        end
    end

    initial begin
        logic [7:0] g, b;
        logic       r;
        reset_n       = 1'b0;
        tp_if.gpio_in = 8'h00;
        tp_if.bypass  = 8'h00;
        for (int s = 0; s < NSEG; s++) begin
            for (int c = 0; c < SEGL; c++) begin
                @(posedge clk);
                #1;
                stim(s, c, g, b, r);
                tp_if.gpio_in = g;
                tp_if.bypass  = b;
                reset_n       = r;
                exp_q.push_back(expect_for(s, c));
            end
        end
        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
